// File: rtl/mvu_ram_pkg.sv
// Shared constants and elaboration-time parameter checks for the MVU RAM family.
// Compile this file first: the check macro below is used by every RAM top.
`ifndef MVU_RAM_PKG_SV
`define MVU_RAM_PKG_SV

package mvu_ram_pkg;

  localparam int unsigned RAM_RDLAT_MIN = 1;
  localparam int unsigned RAM_RDLAT_MAX = 4;

  function automatic int unsigned nlane(int unsigned bdword, int unsigned bdlane);
    return (bdlane == 0) ? 0 : bdword / bdlane;
  endfunction

  function automatic bit params_ok(int unsigned bdword, int unsigned bdlane,
                                   int unsigned rdlat, int unsigned wrfwd);
    if (bdlane == 0 || bdword == 0) return 1'b0;
    if (bdword % bdlane != 0) return 1'b0;
    if (rdlat < RAM_RDLAT_MIN || rdlat > RAM_RDLAT_MAX) return 1'b0;
    return wrfwd <= 1;
  endfunction

endpackage

`define MVU_RAM_PARAM_CHECK(W, L, R, F) \
  if (!mvu_ram_pkg::params_ok((W), (L), (R), (F))) begin : g_bad_params \
    $fatal(1, "mvu_ram: illegal BDWORD/BDLANE/RDLAT/WRFWD combination"); \
  end

`endif

// File: rtl/ram_simple2port_pipe_if.sv
// Read/write bus of the pipelined 1R/1W RAM; master is the MVU controller side.
interface ram_simple2port_pipe_if
  import mvu_ram_pkg::*;
#(
  parameter int unsigned BDADDR = 12,
  parameter int unsigned BDWORD = 2048,
  parameter int unsigned BDLANE = 32,
  parameter int unsigned NLANE  = nlane(BDWORD, BDLANE)
) ();

  logic              rd_en;
  logic [BDADDR-1:0] rd_addr;
  logic [BDWORD-1:0] rd_word;
  logic              rd_valid;
  logic              wr_en;
  logic [BDADDR-1:0] wr_addr;
  logic [NLANE-1:0]  wr_mask;
  logic [BDWORD-1:0] wr_word;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_mask, wr_word,
    input  rd_word, rd_valid
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_mask, wr_word,
    output rd_word, rd_valid
  );

endinterface

// File: rtl/ram_mask_array.sv
// Bare lane-masked storage with a registered read port; no reset so the
// array maps onto block RAM. A same-address read returns the old contents.
module ram_mask_array
  import mvu_ram_pkg::*;
#(
  parameter int unsigned BDADDR = 12,
  parameter int unsigned BDWORD = 2048,
  parameter int unsigned BDLANE = 32,
  localparam int unsigned NLANE = nlane(BDWORD, BDLANE)
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [BDADDR-1:0] wr_addr_i,
  input  logic [NLANE-1:0]  wr_mask_i,
  input  logic [BDWORD-1:0] wr_word_i,
  input  logic              rd_en_i,
  input  logic [BDADDR-1:0] rd_addr_i,
  output logic [BDWORD-1:0] rd_word_o
);

  logic [BDWORD-1:0] mem [2**BDADDR];
  logic [BDWORD-1:0] rd_word_q;

  // Array access kept inside one clocked block in the shape inference tools expect.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < NLANE; i++) begin
        if (wr_mask_i[i]) mem[wr_addr_i][i*BDLANE +: BDLANE] <= wr_word_i[i*BDLANE +: BDLANE];
      end
    end
    if (rd_en_i) rd_word_q <= mem[rd_addr_i];
  end

  assign rd_word_o = rd_word_q;

endmodule

// File: rtl/ram_simple2port_pipe.sv
// Pipelined 1R/1W RAM: masked writes, RDLAT-cycle reads with rd_valid, optional
// same-cycle write forwarding, and an output that holds between valid reads.
module ram_simple2port_pipe
  import mvu_ram_pkg::*;
#(
  parameter int unsigned BDADDR = 12,
  parameter int unsigned BDWORD = 2048,
  parameter int unsigned BDLANE = 32,
  parameter int unsigned RDLAT  = 2,
  parameter int unsigned WRFWD  = 1
) (
  input logic                   clk,
  input logic                   rst,
  ram_simple2port_pipe_if.slave bus
);

  localparam int unsigned NLANE = nlane(BDWORD, BDLANE);

  `MVU_RAM_PARAM_CHECK(BDWORD, BDLANE, RDLAT, WRFWD)

  logic [BDWORD-1:0] arr_word;
  logic              collide;
  logic [NLANE-1:0]  fwd_mask_d, fwd_mask_q;
  logic [BDWORD-1:0] fwd_word_d, fwd_word_q;
  logic [BDWORD-1:0] merged;
  logic [RDLAT-1:0]  vld_d, vld_q;
  logic [BDWORD-1:0] out_dat;
  logic [BDWORD-1:0] hold_d, hold_q;
  logic [BDWORD-1:0] rd_word;

  ram_mask_array #(
    .BDADDR (BDADDR),
    .BDWORD (BDWORD),
    .BDLANE (BDLANE)
  ) u_array (
    .clk_i     (clk),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_mask_i (bus.wr_mask),
    .wr_word_i (bus.wr_word),
    .rd_en_i   (bus.rd_en),
    .rd_addr_i (bus.rd_addr),
    .rd_word_o (arr_word)
  );

  // The array returns old data on a collision; the write lanes are captured here
  // in step with the array read register and overlaid one cycle later.
  always_comb begin
    collide    = (WRFWD != 0) && bus.rd_en && bus.wr_en && (bus.rd_addr == bus.wr_addr);
    fwd_mask_d = collide ? bus.wr_mask : '0;
    fwd_word_d = collide ? bus.wr_word : fwd_word_q;
    merged     = arr_word;
    for (int i = 0; i < NLANE; i++) begin
      if (fwd_mask_q[i]) merged[i*BDLANE +: BDLANE] = fwd_word_q[i*BDLANE +: BDLANE];
    end
    vld_d[0] = bus.rd_en;
    for (int k = 1; k < RDLAT; k++) vld_d[k] = vld_q[k-1];
  end

  if (RDLAT == 1) begin : g_lat1
    assign out_dat = merged;
  end else begin : g_latn
    logic [BDWORD-1:0] dat_d [RDLAT-1];
    logic [BDWORD-1:0] dat_q [RDLAT-1];

    // Stages only load behind a valid read so idle cycles do not toggle data.
    always_comb begin
      dat_d[0] = vld_q[0] ? merged : dat_q[0];
      for (int j = 1; j < RDLAT - 1; j++) dat_d[j] = vld_q[j] ? dat_q[j-1] : dat_q[j];
    end

    always_ff @(posedge clk) begin
      dat_q <= dat_d;
    end

    assign out_dat = dat_q[RDLAT-2];
  end

  always_comb begin
    rd_word = vld_q[RDLAT-1] ? out_dat : hold_q;
    hold_d  = rd_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      fwd_mask_q <= '0;
      hold_q     <= '0;
    end else begin
      vld_q      <= vld_d;
      fwd_mask_q <= fwd_mask_d;
      hold_q     <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    fwd_word_q <= fwd_word_d;
  end

  assign bus.rd_word  = rd_word;
  assign bus.rd_valid = vld_q[RDLAT-1];

endmodule

// File: tb/tb_ram_simple2port_pipe.sv
// Scoreboard bench: two RAM instances (RDLAT=2 forwarding, RDLAT=3 non-forwarding)
// share one stimulus stream; a negedge monitor checks each output against its queue.
module tb_ram_simple2port_pipe;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 128;
  localparam int unsigned LW    = 32;
  localparam int unsigned NL    = 4;
  localparam int unsigned DEPTH = 32;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  typedef struct {
    logic [DW-1:0] word;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_simple2port_pipe_if #(.BDADDR(AW), .BDWORD(DW), .BDLANE(LW)) bus_a ();
  ram_simple2port_pipe_if #(.BDADDR(AW), .BDWORD(DW), .BDLANE(LW)) bus_b ();

  ram_simple2port_pipe #(
    .BDADDR(AW), .BDWORD(DW), .BDLANE(LW), .RDLAT(LAT_A), .WRFWD(1)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ram_simple2port_pipe #(
    .BDADDR(AW), .BDWORD(DW), .BDLANE(LW), .RDLAT(LAT_B), .WRFWD(0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  exp_t          exp_q [2][$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last  [2];
  logic          obs_v [2];
  logic [DW-1:0] obs_w [2];
  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, req);
    end
  endtask

  task automatic drive(bit re, int ra, bit we, int wa, logic [NL-1:0] wm, logic [DW-1:0] ww);
    bus_a.rd_en = re;  bus_a.rd_addr = AW'(ra);
    bus_a.wr_en = we;  bus_a.wr_addr = AW'(wa);  bus_a.wr_mask = wm;  bus_a.wr_word = ww;
    bus_b.rd_en = re;  bus_b.rd_addr = AW'(ra);
    bus_b.wr_en = we;  bus_b.wr_addr = AW'(wa);  bus_b.wr_mask = wm;  bus_b.wr_word = ww;
  endtask

  // One clock of stimulus; pushes the expected read result for both instances.
  task automatic cycle_io(bit re, int ra, bit we, int wa, logic [NL-1:0] wm,
                          logic [DW-1:0] ww);
    logic [DW-1:0] old_w, fwd_w;
    drive(re, ra, we, wa, wm, ww);
    if (re && !rst) begin
      old_w = model[ra];
      fwd_w = old_w;
      if (we && wa == ra) begin
        for (int i = 0; i < NL; i++) if (wm[i]) fwd_w[i*LW +: LW] = ww[i*LW +: LW];
      end
      exp_q[0].push_back('{fwd_w, cyc + LAT_A});
      exp_q[1].push_back('{old_w, cyc + LAT_B});
    end
    if (we) begin
      for (int i = 0; i < NL; i++) if (wm[i]) model[wa][i*LW +: LW] = ww[i*LW +: LW];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle_io(0, 0, 0, 0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t  e;
    string pn;
    obs_v[0] = bus_a.rd_valid;  obs_w[0] = bus_a.rd_word;
    obs_v[1] = bus_b.rd_valid;  obs_w[1] = bus_b.rd_word;
    for (int p = 0; p < 2; p++) begin
      pn = (p == 0) ? "a" : "b";
      if (rst) begin
        check({pn, "_rst_valid"}, DW'(obs_v[p]), '0);
        check({pn, "_rst_word"}, obs_w[p], '0);
        last[p] = '0;
      end else begin
        while (exp_q[p].size() > 0 && exp_q[p][0].due < cyc) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s_missed_valid: got none by cyc %0d want valid at %0d", pn, cyc,
                   exp_q[p][0].due);
          void'(exp_q[p].pop_front());
        end
        if (obs_v[p]) begin
          if (exp_q[p].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_spurious_valid: got rd_valid=1 @cyc %0d want 0", pn, cyc);
          end else begin
            e = exp_q[p].pop_front();
            check({pn, "_latency"}, DW'(cyc), DW'(e.due));
            check({pn, "_rd_word"}, obs_w[p], e.word);
            last[p] = e.word;
          end
        end else begin
          check({pn, "_hold"}, obs_w[p], last[p]);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] ones, x0, x1, x2, sv;
    logic [31:0]   v32;
    ones = '1;
    x0   = {4{32'h0BAD_F00D}};
    x1   = {4{32'hC0DE_1111}};
    x2   = {4{32'h2222_3333}};
    drive(0, 0, 0, 0, '0, '0);
    #1 rst = 1'b1;

    // Reset held three cycles with a read request pending
    for (int i = 0; i < 3; i++) cycle_io(1, 3, 0, 0, '0, '0);
    rst = 1'b0;
    idle(LAT_B + 2);

    // Latency and in-flight isolation
    cycle_io(0, 0, 1, 5, 4'hF, {16{8'hA5}});
    cycle_io(1, 5, 0, 0, '0, '0);
    idle(4);
    cycle_io(1, 5, 0, 0, '0, '0);
    cycle_io(0, 0, 1, 5, 4'hF, {16{8'h5A}});
    cycle_io(1, 5, 0, 0, '0, '0);
    idle(4);

    // Lane mask, including an all-zero mask
    cycle_io(0, 0, 1, 7, 4'hF, ones);
    cycle_io(0, 0, 1, 7, 4'b0101, '0);
    cycle_io(0, 0, 1, 7, 4'b0000, {4{32'h1234_5678}});
    cycle_io(1, 7, 0, 0, '0, '0);
    idle(4);

    // Same-cycle collisions, full and partial mask
    cycle_io(0, 0, 1, 9, 4'hF, x0);
    cycle_io(1, 9, 1, 9, 4'hF, x1);
    cycle_io(1, 9, 0, 0, '0, '0);
    cycle_io(1, 9, 1, 9, 4'b0011, x2);
    cycle_io(1, 9, 0, 0, '0, '0);
    idle(4);

    // Streaming reads of 0..15 plus the top address
    for (int i = 0; i < 16; i++) begin
      v32 = 32'hD00D_0000 + 32'(i);
      sv  = {4{v32}};
      cycle_io(0, 0, 1, i, 4'hF, sv);
    end
    cycle_io(0, 0, 1, DEPTH - 1, 4'hF, {4{32'hFEED_BEEF}});
    for (int i = 0; i < 16; i++) cycle_io(1, i, 0, 0, '0, '0);
    cycle_io(1, DEPTH - 1, 0, 0, '0, '0);
    idle(6);

    // Reset pulse while two reads are in flight
    drive(1, 9, 0, 0, '0, '0);
    @(posedge clk);
    #1;
    drive(1, 9, 0, 0, '0, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
    cycle_io(1, 9, 0, 0, '0, '0);
    idle(2);

    for (int i = 0; i < 20 && (exp_q[0].size() + exp_q[1].size()) > 0; i++) idle(1);
    if ((exp_q[0].size() + exp_q[1].size()) > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d/%0d reads outstanding want 0", exp_q[0].size(),
               exp_q[1].size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
